// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control unit: sequences PC, register-file, ALU and memory strobes
// per instruction class, with a start/busy/done handshake and a retired-instruction counter.
module mips_multicycle_controller #(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] instruction,
    input  logic        zeroflag,
    output logic        ldinpc,
    output logic        initpc,
    output logic        JumpSrc,
    output logic        PCsignal,
    output logic        PCSrc,
    output logic        RegDst,
    output logic        RegWSrc,
    output logic        WriteSrc,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        ALUSrc,
    output logic [2:0]  ALUoperation,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [15:0] retired
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t      state;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] retired_cnt;

    logic r_alu, r_jr, i_addi, i_slti, i_lw, i_sw, i_beq, i_j, i_jal, unsupported;
    logic unused_instr_bits;

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // Only opcode and funct steer the sequence; the register fields belong to the datapath.
    assign unused_instr_bits = ^instruction[25:6];

    always_comb begin
        r_alu  = (op == OP_RTYPE) && (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
        r_jr   = (op == OP_RTYPE) && (fn == FN_JR);
        i_addi = (op == OP_ADDI);
        i_slti = (op == OP_SLTI);
        i_lw   = (op == OP_LW);
        i_sw   = (op == OP_SW);
        i_beq  = (op == OP_BEQ);
        i_j    = (op == OP_J);
        i_jal  = (op == OP_JAL);
        unsupported = !(r_alu || r_jr || i_addi || i_slti || i_lw || i_sw ||
                        i_beq || i_j || i_jal);
    end

    always_comb begin
        ldinpc       = 1'b0;
        initpc       = 1'b0;
        JumpSrc      = 1'b0;
        PCsignal     = 1'b0;
        PCSrc        = 1'b0;
        RegDst       = 1'b0;
        RegWSrc      = 1'b0;
        WriteSrc     = 1'b0;
        RegWrite     = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemtoReg     = 1'b0;
        ALUSrc       = 1'b0;
        ALUoperation = ALU_AND;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            S_IDLE: ;
            S_INIT: begin
                busy   = 1'b1;
                initpc = 1'b1;
            end
            S_DECODE: busy = 1'b1;
            S_EXEC: begin
                busy = 1'b1;
                if (r_alu) begin
                    ALUoperation = funct_alu(fn);
                end else if (i_addi || i_lw || i_sw) begin
                    ALUSrc       = 1'b1;
                    ALUoperation = ALU_ADD;
                end else if (i_slti) begin
                    ALUSrc       = 1'b1;
                    ALUoperation = ALU_SLT;
                end else if (i_beq) begin
                    ALUoperation = ALU_SUB;
                    ldinpc       = 1'b1;
                    PCSrc        = zeroflag;
                end else if (i_j || i_jal) begin
                    ldinpc   = 1'b1;
                    PCsignal = 1'b1;
                    JumpSrc  = 1'b1;
                    RegWrite = i_jal;
                    RegWSrc  = i_jal;
                    WriteSrc = i_jal;
                end else if (r_jr) begin
                    ldinpc   = 1'b1;
                    PCsignal = 1'b1;
                end else begin
                    ldinpc = 1'b1;
                end
            end
            S_MEM: begin
                busy         = 1'b1;
                ALUSrc       = 1'b1;
                ALUoperation = ALU_ADD;
                MemRead      = i_lw;
                MemWrite     = i_sw;
                ldinpc       = i_sw;
            end
            S_WB: begin
                busy     = 1'b1;
                RegWrite = 1'b1;
                ldinpc   = 1'b1;
                if (r_alu) begin
                    RegDst       = 1'b1;
                    ALUoperation = funct_alu(fn);
                end else if (i_lw) begin
                    MemRead      = 1'b1;
                    MemtoReg     = 1'b1;
                    ALUSrc       = 1'b1;
                    ALUoperation = ALU_ADD;
                end else begin
                    // addi/slti write the ALU result, so the immediate operation stays applied.
                    ALUSrc       = 1'b1;
                    ALUoperation = i_slti ? ALU_SLT : ALU_ADD;
                end
            end
            S_HALT: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            op          <= 6'd0;
            fn          <= 6'd0;
            illegal     <= 1'b0;
            retired_cnt <= 16'd0;
        end else begin
            retired_cnt <= retired_cnt + {15'd0, ldinpc};
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_INIT;
                        illegal     <= 1'b0;
                        retired_cnt <= 16'd0;
                    end
                end
                S_INIT: state <= S_DECODE;
                S_DECODE: begin
                    op    <= instruction[31:26];
                    fn    <= instruction[5:0];
                    state <= (instruction[31:26] == HALT_OP) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    if (unsupported)
                        illegal <= 1'b1;
                    if (i_lw || i_sw)
                        state <= S_MEM;
                    else if (r_alu || i_addi || i_slti)
                        state <= S_WB;
                    else
                        state <= S_DECODE;
                end
                S_MEM:   state <= i_lw ? S_WB : S_DECODE;
                S_WB:    state <= S_DECODE;
                S_HALT:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign retired = retired_cnt;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for mips_multicycle_controller: a per-instruction-class model of the
// expected strobe sequence, checked every cycle, plus literal checks that pin the model.
module tb_mips_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst, start, zeroflag;
    logic [31:0] instruction;
    logic        ldinpc, initpc, JumpSrc, PCsignal, PCSrc, RegDst, RegWSrc, WriteSrc;
    logic        RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, busy, done, illegal;
    logic [2:0]  ALUoperation;
    logic [15:0] retired;

    mips_multicycle_controller dut (
        .clk(clk), .rst(rst), .start(start), .instruction(instruction), .zeroflag(zeroflag),
        .ldinpc(ldinpc), .initpc(initpc), .JumpSrc(JumpSrc), .PCsignal(PCsignal), .PCSrc(PCSrc),
        .RegDst(RegDst), .RegWSrc(RegWSrc), .WriteSrc(WriteSrc), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc),
        .ALUoperation(ALUoperation), .busy(busy), .done(done), .illegal(illegal),
        .retired(retired)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] M_LD = 16'h8000, M_INIT = 16'h4000, M_JSRC = 16'h2000;
    localparam logic [15:0] M_PCSIG = 16'h1000, M_PCSRC = 16'h0800, M_RDST = 16'h0400;
    localparam logic [15:0] M_RWSRC = 16'h0200, M_WSRC = 16'h0100, M_RW = 16'h0080;
    localparam logic [15:0] M_MR = 16'h0040, M_MW = 16'h0020, M_M2R = 16'h0010, M_ASRC = 16'h0008;
    localparam logic [15:0] A_AND = 16'h0, A_OR = 16'h1, A_ADD = 16'h2, A_SUB = 16'h6, A_SLT = 16'h7;

    localparam logic [31:0] I_ADD = 32'h00221820, I_SUB = 32'h00221822, I_SLT = 32'h0022182A;
    localparam logic [31:0] I_AND = 32'h00221824, I_OR = 32'h00221825, I_BADFN = 32'h00221821;
    localparam logic [31:0] I_LW = 32'h8C220004, I_SW = 32'hAC220004, I_BEQ = 32'h10220003;
    localparam logic [31:0] I_ADDI = 32'h20220005, I_SLTI = 32'h28220005;
    localparam logic [31:0] I_J = 32'h08000020, I_JAL = 32'h0C000010, I_JR = 32'h03E00008;
    localparam logic [31:0] I_ILL = 32'h44000000, I_HALT = 32'hFC000000;

    logic [15:0] dut_s;
    assign dut_s = {ldinpc, initpc, JumpSrc, PCsignal, PCSrc, RegDst, RegWSrc, WriteSrc,
                    RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUoperation};

    // Model state, written only by the stimulus process
    logic [15:0] exp_s, exp_retired;
    logic        exp_busy, exp_done, exp_illegal, chk_en;
    logic [15:0] seq [4];
    int          seq_n;
    logic        seq_ill, seq_halt;
    int          start_cyc;
    string       lit_name;
    logic [31:0] lit_got, lit_want;
    int          lit_seq = 0;

    // Written only by the compare process / cycle counter
    int checks = 0, errors = 0, lit_seen = 0;
    int cyc = 0, done_cyc = 0, init_cnt = 0, wb_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (dut_s !== exp_s) begin
                errors++;
                $display("FAIL strobes t=%0t got %h want %h", $time, dut_s, exp_s);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy t=%0t got %b want %b", $time, busy, exp_busy);
            end
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done t=%0t got %b want %b", $time, done, exp_done);
            end
            checks++;
            if (illegal !== exp_illegal) begin
                errors++;
                $display("FAIL illegal t=%0t got %b want %b", $time, illegal, exp_illegal);
            end
            checks++;
            if (retired !== exp_retired) begin
                errors++;
                $display("FAIL retired t=%0t got %h want %h", $time, retired, exp_retired);
            end
            if (done === 1'b1) done_cyc = cyc;
            if (initpc === 1'b1) init_cnt++;
            if (RegDst === 1'b1 && RegWrite === 1'b1) wb_cnt++;
        end
        if (lit_seq != lit_seen) begin
            lit_seen = lit_seq;
            checks++;
            if (lit_got !== lit_want) begin
                errors++;
                $display("FAIL %s got %0h want %0h", lit_name, lit_got, lit_want);
            end
        end
    end

    // Expected per-cycle strobes of one instruction, DECODE first, by instruction class.
    task automatic expand(input logic [31:0] ins, input logic zf);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        for (int i = 0; i < 4; i++) seq[i] = 16'h0;
        seq_n = 2; seq_ill = 1'b0; seq_halt = 1'b0;
        if (op == 6'b111111) begin
            seq_n = 1; seq_halt = 1'b1;
        end else if (op == 6'b000000 && fn == 6'b001000) begin
            seq[1] = M_LD | M_PCSIG;
        end else if (op == 6'b000000 && (fn == 6'b100000 || fn == 6'b100010 ||
                     fn == 6'b100100 || fn == 6'b100101 || fn == 6'b101010)) begin
            logic [15:0] a;
            a = (fn == 6'b100000) ? A_ADD : (fn == 6'b100010) ? A_SUB :
                (fn == 6'b100100) ? A_AND : (fn == 6'b100101) ? A_OR : A_SLT;
            seq_n = 3; seq[1] = a; seq[2] = M_RW | M_LD | M_RDST | a;
        end else if (op == 6'b001000 || op == 6'b001010) begin
            logic [15:0] a;
            a = (op == 6'b001000) ? A_ADD : A_SLT;
            seq_n = 3; seq[1] = M_ASRC | a; seq[2] = M_RW | M_LD | M_ASRC | a;
        end else if (op == 6'b100011) begin
            seq_n = 4;
            seq[1] = M_ASRC | A_ADD;
            seq[2] = M_ASRC | A_ADD | M_MR;
            seq[3] = M_RW | M_LD | M_MR | M_M2R | M_ASRC | A_ADD;
        end else if (op == 6'b101011) begin
            seq_n = 3; seq[1] = M_ASRC | A_ADD; seq[2] = M_ASRC | A_ADD | M_MW | M_LD;
        end else if (op == 6'b000100) begin
            seq[1] = M_LD | A_SUB | (zf ? M_PCSRC : 16'h0);
        end else if (op == 6'b000010) begin
            seq[1] = M_LD | M_PCSIG | M_JSRC;
        end else if (op == 6'b000011) begin
            seq[1] = M_LD | M_PCSIG | M_JSRC | M_RW | M_RWSRC | M_WSRC;
        end else begin
            seq[1] = M_LD; seq_ill = 1'b1;
        end
    endtask

    // Called at posedge+1: sets this cycle's expectation, then advances one clock.
    task automatic expect_cycle(input logic [15:0] s, input logic b, input logic d, input logic ill_set);
        exp_s = s; exp_busy = b; exp_done = d;
        @(posedge clk); #1;
        if ((s & M_LD) != 16'h0) exp_retired = exp_retired + 16'd1;
        if (ill_set) exp_illegal = 1'b1;
    endtask

    task automatic set_idle();
        exp_s = 16'h0; exp_busy = 1'b0; exp_done = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        expect_cycle(16'h0, 1'b0, 1'b0, 1'b0);
        start_cyc = cyc;
        exp_retired = 16'd0; exp_illegal = 1'b0;
        start = 1'b0;
        expect_cycle(M_INIT, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic zf, input logic frc);
        instruction = ins; zeroflag = zf;
        expand(ins, zf);
        for (int i = 0; i < seq_n; i++) begin
            if (i == 0 && frc) begin
                force dut.retired_cnt = 16'hFFFF;
                exp_retired = 16'hFFFF;
            end
            expect_cycle(seq[i], 1'b1, 1'b0, (i == 1) && seq_ill);
            if (i == 0 && frc) release dut.retired_cnt;
        end
        if (seq_halt) begin
            expect_cycle(16'h0, 1'b1, 1'b1, 1'b0);
            set_idle();
        end
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        lit_name = name; lit_got = got; lit_want = want;
        lit_seq++;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rw_pre, rw_rst, busy_rst, ld_rst;
        logic [15:0] ret_pre, ret_rst;
        int          init_base, wb_base;
        rst = 1'b1; start = 1'b0; zeroflag = 1'b0; instruction = 32'h0;
        chk_en = 1'b0; exp_retired = 16'h0; exp_illegal = 1'b0; set_idle();
        @(posedge clk); #1;
        chk_en = 1'b1;
        expect_cycle(16'h0, 1'b0, 1'b0, 1'b0);
        expect_cycle(16'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        expect_cycle(16'h0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while an add sits in WB
        do_start();
        run_instr(I_J, 1'b0, 1'b0);
        instruction = I_ADD;
        expect_cycle(16'h0, 1'b1, 1'b0, 1'b0);
        expect_cycle(A_ADD, 1'b1, 1'b0, 1'b0);
        chk_en = 1'b0;
        rw_pre = RegWrite; ret_pre = retired;
        #2 rst = 1'b1;
        #1 rw_rst = RegWrite; busy_rst = busy; ret_rst = retired; ld_rst = ldinpc;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_retired = 16'h0; exp_illegal = 1'b0; set_idle();
        chk_en = 1'b1;
        lit("wb_regwrite_before_rst", {31'd0, rw_pre}, 32'd1);
        lit("retired_before_rst", {16'd0, ret_pre}, 32'd1);
        lit("regwrite_async_drop", {31'd0, rw_rst}, 32'd0);
        lit("ldinpc_async_drop", {31'd0, ld_rst}, 32'd0);
        lit("busy_async_drop", {31'd0, busy_rst}, 32'd0);
        lit("retired_async_clear", {16'd0, ret_rst}, 32'd0);

        // Three R-type instructions then halt
        init_base = init_cnt; wb_base = wb_cnt;
        do_start();
        run_instr(I_ADD, 1'b0, 1'b0);
        run_instr(I_SUB, 1'b0, 1'b0);
        run_instr(I_SLT, 1'b0, 1'b0);
        run_instr(I_HALT, 1'b0, 1'b0);
        lit("rtype_retired", {16'd0, retired}, 32'd3);
        lit("done_latency", done_cyc - start_cyc, 32'd11);
        lit("initpc_pulses", init_cnt - init_base, 32'd1);
        lit("rtype_wb_cycles", wb_cnt - wb_base, 32'd3);

        // Memory, branch and immediate classes, with start held high while busy
        do_start();
        start = 1'b1;
        run_instr(I_LW, 1'b0, 1'b0);
        run_instr(I_SW, 1'b0, 1'b0);
        run_instr(I_BEQ, 1'b1, 1'b0);
        run_instr(I_BEQ, 1'b0, 1'b0);
        run_instr(I_ADDI, 1'b0, 1'b0);
        run_instr(I_SLTI, 1'b0, 1'b0);
        run_instr(I_AND, 1'b0, 1'b0);
        run_instr(I_OR, 1'b0, 1'b0);
        start = 1'b0;
        run_instr(I_HALT, 1'b0, 1'b0);
        lit("mixed_retired", {16'd0, retired}, 32'd8);
        lit("mixed_busy_idle", {31'd0, busy}, 32'd0);

        // Jumps
        do_start();
        run_instr(I_JAL, 1'b0, 1'b0);
        run_instr(I_JR, 1'b0, 1'b0);
        run_instr(I_J, 1'b0, 1'b0);
        run_instr(I_HALT, 1'b0, 1'b0);
        lit("jump_retired", {16'd0, retired}, 32'd3);

        // Unsupported opcode / funct, then retired wrap from 16'hFFFF
        do_start();
        run_instr(I_ILL, 1'b0, 1'b0);
        run_instr(I_BADFN, 1'b0, 1'b0);
        run_instr(I_ADD, 1'b0, 1'b1);
        run_instr(I_HALT, 1'b0, 1'b0);
        lit("illegal_sticky", {31'd0, illegal}, 32'd1);
        lit("retired_wrap", {16'd0, retired}, 32'd0);

        // A new start clears the sticky flag
        do_start();
        run_instr(I_HALT, 1'b0, 1'b0);
        lit("illegal_cleared", {31'd0, illegal}, 32'd0);

        chk_en = 1'b0;
        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
